braille_playback_ctrl: RTL
==========================

BRAILLE_PLAYBACK_CTRL -- requirements
Module: braille_playback_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to accept a button level.
REQ-002 SHALL have parameter TICK_CYCLES, default 1000: clk cycles per dwell tick.
REQ-003 SHALL have parameter PULSE_CYCLES, default 4: length of the next_out high phase, and of the low gap after it.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_next  input  1  raw, asynchronous, bouncy button, active-high.
REQ-007 auto_en  input  1  1 = auto-advance after the dwell time.
REQ-008 pause  input  1  1 = freeze the auto-advance dwell count.
REQ-009 dwell_sel  input  4  dwell = (dwell_sel+1)*TICK_CYCLES cycles.
REQ-010 msg_start  input  1  one-cycle pulse: a message of msg_size characters is now loaded in the reader.
REQ-011 msg_size  input  8  character count, sampled on msg_start.
REQ-012 next_out  output  1  drives the reader's next input; each high-to-low transition advances the reader by one step.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 char_idx  output  8  number of advance steps issued in the current message.
REQ-015 done  output  1  one-cycle pulse after the final step (the END step).

Function
REQ-016 Button path: 2-flop synchroniser, then debounce; clean level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-017 Press event: one cycle on the 0->1 transition of the clean level; one event per physical press regardless of hold time.
REQ-018 States: IDLE, WAIT, PULSE, GAP, DONE.
REQ-019 IDLE: next_out=0, busy=0.
- On msg_start: remaining = msg_size+1 (9-bit; the extra step is the reader END step), char_idx = 0, go to WAIT.
REQ-020 WAIT: dwell counter clears on entry.
- Dwell counter advances only while auto_en=1 and pause=0; it holds its value while paused.
REQ-021 WAIT exit: go to PULSE on a press event, or on auto_en=1 and pause=0 and dwell count = dwell target.
- A press wins over a simultaneous dwell expiry; exactly one step is taken.
- dwell_sel is sampled continuously.
- If dwell_sel is lowered below the current count, WAIT exits on the next counting cycle.
REQ-022 PULSE: next_out=1 for exactly PULSE_CYCLES cycles.
- Then next_out=0, remaining decrements, and char_idx increments, saturating at 255.
- Next state is DONE if remaining reaches 0, else GAP.
REQ-023 GAP: next_out=0 for PULSE_CYCLES cycles, then go to WAIT.
REQ-024 Press events and dwell expiry during PULSE, GAP or DONE are discarded, not queued.
REQ-025 DONE: done=1 for one cycle, then go to IDLE; char_idx holds until the next msg_start.
REQ-026 msg_start in any non-IDLE state aborts the current message:
- next_out=0 on the following cycle;
- counters reload per REQ-019;
- go to WAIT.
REQ-027 msg_size=0: remaining=1; exactly one step is issued, then DONE.
REQ-028 Toggling auto_en to 0 in WAIT halts auto-advance; the dwell count holds; presses still advance.
REQ-029 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-030 Reset asserted: all outputs 0 asynchronously; state=IDLE; debounce, dwell, tick, pulse and remaining counters cleared.
REQ-031 The clean button level resets to 0, so a button held through reset release yields no press until it is released and pressed again.
REQ-032 Reset mid-PULSE: next_out=0 immediately and no further steps; because next_out goes 1->0, a reader sharing this reset treats the transition as if reset.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=10, PULSE_CYCLES=2)
REQ-033 Manual mode, msg_size=3, auto_en=0, 4 clean presses -> 4 next_out pulses each 2 cycles high; char_idx 1,2,3,4; done pulse after the 4th; busy=0 afterwards.
REQ-034 Bounce: btn_next toggling every cycle for 3 cycles, then high for 10 cycles -> exactly one press event and one next_out pulse.
REQ-035 Auto mode, dwell_sel=2, msg_size=1:
- first next_out rise 30 cycles after WAIT entry;
- pulse of 2 cycles, gap of 2 cycles;
- second rise 30 cycles after re-entering WAIT, then done.
REQ-036 Pause: pause=1 held 50 cycles at dwell count 15 -> no pulse while paused; pulse 15 counting cycles after release.
REQ-037 Abort: msg_start with msg_size=5 during PULSE of an earlier message -> next_out=0 next cycle; char_idx=0; 6 further steps required before done.
REQ-038 Edge cases:
- msg_size=0 -> single pulse, then done;
- msg_size=255 -> 256 pulses, char_idx saturates at 255, then done.

Source files
------------

// File: rtl/braille_playback_ctrl.sv
`default_nettype none
// ============================================================================
// braille_playback_ctrl : debounced-button / auto-dwell step sequencer that
//                         pulses a Braille reader's next input once per char.
// Revision 1.0
// ============================================================================
module braille_playback_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_CYCLES     = 1000,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic       pause,
  input  logic [3:0] dwell_sel,
  input  logic       msg_start,
  input  logic [7:0] msg_size,
  output logic       next_out,
  output logic       busy,
  output logic [7:0] char_idx,
  output logic       done
);

  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PUL_W  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [PUL_W-1:0]  PUL_LAST  = PUL_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic             sync1_q;
  logic             sync2_q;
  logic             clean_q;
  logic             armed_q;
  logic             press_q;
  logic [DEB_W-1:0] deb_cnt_q;

  // Synchronisers reset high so a button held through reset debounces to a
  // clean 1 without arming; a press only counts after a low has been seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      clean_q   <= 1'b0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= btn_next;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (!clean_q && !sync2_q) begin
        armed_q <= 1'b1;
      end
      if (sync2_q == clean_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_cnt_q <= '0;
        clean_q   <= sync2_q;
        press_q   <= sync2_q & armed_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  state_t            state_q;
  logic [8:0]        remaining_q;
  logic [TICK_W-1:0] tick_q;
  logic [3:0]        dwell_q;
  logic [PUL_W-1:0]  pulse_q;

  logic counting;
  logic dwell_hit;

  // Dwell spans (dwell_sel+1) ticks; a target lowered below the count fires at once.
  assign counting  = auto_en && !pause;
  assign dwell_hit = counting &&
                     ((dwell_q > dwell_sel) ||
                      ((dwell_q == dwell_sel) && (tick_q == TICK_LAST)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      next_out    <= 1'b0;
      busy        <= 1'b0;
      char_idx    <= 8'd0;
      done        <= 1'b0;
      remaining_q <= 9'd0;
      tick_q      <= '0;
      dwell_q     <= 4'd0;
      pulse_q     <= '0;
    end else begin
      done <= 1'b0;
      if (msg_start) begin
        state_q     <= S_WAIT;
        next_out    <= 1'b0;
        busy        <= 1'b1;
        char_idx    <= 8'd0;
        remaining_q <= {1'b0, msg_size} + 9'd1;
        tick_q      <= '0;
        dwell_q     <= 4'd0;
        pulse_q     <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            busy     <= 1'b0;
            next_out <= 1'b0;
          end
          S_WAIT: begin
            if (press_q || dwell_hit) begin
              state_q  <= S_PULSE;
              next_out <= 1'b1;
              pulse_q  <= '0;
            end else if (counting) begin
              if (tick_q == TICK_LAST) begin
                tick_q  <= '0;
                dwell_q <= dwell_q + 4'd1;
              end else begin
                tick_q <= tick_q + TICK_W'(1);
              end
            end
          end
          S_PULSE: begin
            if (pulse_q == PUL_LAST) begin
              next_out    <= 1'b0;
              pulse_q     <= '0;
              remaining_q <= remaining_q - 9'd1;
              if (char_idx != 8'hFF) begin
                char_idx <= char_idx + 8'd1;
              end
              if (remaining_q == 9'd1) begin
                state_q <= S_DONE;
                done    <= 1'b1;
              end else begin
                state_q <= S_GAP;
              end
            end else begin
              pulse_q <= pulse_q + PUL_W'(1);
            end
          end
          S_GAP: begin
            if (pulse_q == PUL_LAST) begin
              state_q <= S_WAIT;
              pulse_q <= '0;
              tick_q  <= '0;
              dwell_q <= 4'd0;
            end else begin
              pulse_q <= pulse_q + PUL_W'(1);
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            next_out <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
